// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - local-side register port bundle for i2c_slave_regs
interface i2c_slave_regs_if #(
  parameter int AW = 3
);
  logic [AW-1:0] loc_addr_i;
  logic [7:0]    loc_data_o;
  logic          wr_strobe_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
  logic          busy_o;

  // FPGA logic that reads the bank and consumes write events
  modport master (
    output loc_addr_i,
    input  loc_data_o, wr_strobe_o, wr_addr_o, wr_data_o, busy_o
  );

  // the I2C target itself
  modport slave (
    input  loc_addr_i,
    output loc_data_o, wr_strobe_o, wr_addr_o, wr_data_o, busy_o
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with auto-incrementing byte register bank
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h28,
  parameter int         AW         = 3,
  parameter int         FILT_LEN   = 4
) (
  input  logic            sysclk_i,
  input  logic            reset_i,
  inout  wire             scl_pin,
  inout  wire             sda_pin,
  i2c_slave_regs_if.slave loc
);

  localparam int FW    = $clog2(FILT_LEN + 1);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // index 0 is SCL, index 1 is SDA throughout the conditioning path
  logic [1:0]    pin_in;
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [FW-1:0] fcnt [2];

  logic scl_rise, scl_fall, sda_in, start, stop;

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    tx, tx_n;
  logic          sda_oe, sda_oe_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          first, first_n;
  logic          acked, acked_n;
  logic          busy, busy_n;
  logic          store;
  logic [7:0]    mem [DEPTH];

  // SCL is never driven (no stretching); SDA is open-drain
  assign scl_pin = 1'bz;
  assign sda_pin = sda_oe ? 1'b0 : 1'bz;
  assign pin_in  = {sda_pin, scl_pin};

  // two-flop synchronizer, then accept a level only after FILT_LEN equal samples
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= pin_in;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign sda_in   = filt[1];
  assign start    = ~filt[1] & filt_d[1] & filt[0];
  assign stop     = filt[1] & ~filt_d[1] & filt[0];

  // protocol state and its control registers
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= '0;
      sda_oe  <= 1'b0;
      ptr     <= '0;
      first   <= 1'b0;
      acked   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      sda_oe  <= sda_oe_n;
      ptr     <= ptr_n;
      first   <= first_n;
      acked   <= acked_n;
      busy    <= busy_n;
    end
  end

  // next-state: bus conditions win over bit processing in the same cycle
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx;
    sda_oe_n  = sda_oe;
    ptr_n     = ptr;
    first_n   = first;
    acked_n   = acked;
    busy_n    = busy;
    store     = 1'b0;
    if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b1;
    end else if (stop) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ADDR, WR_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = {shreg[6:0], sda_in};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (state == ADDR) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                sda_oe_n = 1'b1;
                state_n  = ADDR_ACK;
              end else begin
                state_n = WAIT_STOP;
              end
            end else begin
              sda_oe_n = 1'b1;
              state_n  = WR_ACK;
              if (first) begin
                ptr_n   = shreg[AW-1:0];
                first_n = 1'b0;
              end else begin
                store = 1'b1;
                ptr_n = ptr + 1'b1;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (!shreg[0]) begin
              state_n = WR_BYTE;
              first_n = 1'b1;
            end else begin
              state_n   = RD_BYTE;
              tx_n      = mem[ptr];
              sda_oe_n  = ~mem[ptr][7];
              bit_cnt_n = 4'd1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WR_BYTE;
          end
        end
        RD_BYTE: begin
          // bit_cnt counts bits already presented; bit 7 went out on entry
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              acked_n  = 1'b0;
              state_n  = RD_ACK;
            end else begin
              sda_oe_n  = ~tx[~bit_cnt[2:0]];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr + 1'b1;
            if (sda_in) state_n = WAIT_STOP;
            else        acked_n = 1'b1;
          end else if (scl_fall && acked) begin
            tx_n      = mem[ptr];
            sda_oe_n  = ~mem[ptr][7];
            bit_cnt_n = 4'd1;
            acked_n   = 1'b0;
            state_n   = RD_BYTE;
          end
        end
        IDLE, WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // register bank, write-event reporting and the registered local read port
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      loc.wr_strobe_o <= 1'b0;
      loc.wr_addr_o   <= '0;
      loc.wr_data_o   <= '0;
      loc.loc_data_o  <= '0;
      loc.busy_o      <= 1'b0;
    end else begin
      loc.wr_strobe_o <= store;
      if (store) begin
        mem[ptr]      <= shreg;
        loc.wr_addr_o <= ptr;
        loc.wr_data_o <= shreg;
      end
      loc.loc_data_o <= mem[loc.loc_addr_i];
      loc.busy_o     <= busy_n;
    end
  end

endmodule
